// File: rtl/display_controller.sv
// Hex 7-segment display controller: shadow/display double buffer, static or
// multiplexed scan output, per-digit blank/blink masks and leading-zero blanking.
module display_controller #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic                    scan_mode,
  output logic [7*NUM_DIGITS-1:0] seg_static,
  output logic [6:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_an,
  output logic [1:0]              dbg_state
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  // Load handshake: a load is taken on any rising edge where load_valid and
  // load_ready are both high; load_ready is a pure decode of the state register.
  logic [1:0]    state;
  logic [DW-1:0] shadow;
  logic [DW-1:0] disp;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          mode_q;

  logic          mode_change;
  logic          presc_wrap;
  logic          idx_last;
  logic          frame_wrap;
  logic          accept;
  logic          do_commit;
  logic [SW-1:0] glyphs;
  logic [6:0]    scan_glyph;
  logic [NUM_DIGITS-1:0] an_next;
  logic          zero_above;
  logic          digit_blank;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign load_ready  = (state == ST_IDLE);
  assign dbg_state   = state;
  assign mode_change = (scan_mode != mode_q);
  assign presc_wrap  = (presc == PW'(SCAN_DIV - 1));
  assign idx_last    = (idx == IW'(NUM_DIGITS - 1));
  // A frame ends only on a genuine index wrap, never on a mode-change clear.
  assign frame_wrap  = !mode_change && presc_wrap && idx_last;
  assign accept      = load_valid && (state == ST_IDLE);
  assign do_commit   = (state == ST_PEND) && (!scan_mode || frame_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      shadow <= '0;
      disp   <= '0;
    end else begin
      case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (accept) begin
            shadow <= load_data;
            state  <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (do_commit) begin
            disp  <= shadow;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      mode_q <= scan_mode;
      if (mode_change) begin
        presc <= '0;
        idx   <= '0;
      end else if (presc_wrap) begin
        presc <= '0;
        idx   <= idx_last ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Walk from the top digit down so zero_above tracks "this and all higher are 0".
  always_comb begin
    zero_above  = 1'b1;
    digit_blank = 1'b0;
    glyphs      = '0;
    scan_glyph  = 7'h7F;
    an_next     = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above && (disp[4*i +: 4] == 4'h0);
      digit_blank = blank_mask[i] || (blink_mask[i] && blink_phase) ||
                    (lz_en && zero_above && (i != 0));
      glyphs[7*i +: 7] = digit_blank ? 7'h7F : hex_glyph(disp[4*i +: 4]);
      if (scan_mode && (idx == IW'(i))) begin
        scan_glyph = glyphs[7*i +: 7];
        an_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_static <= {NUM_DIGITS{7'h40}};
      scan_seg   <= 7'h7F;
      scan_an    <= '1;
    end else begin
      seg_static <= glyphs;
      scan_seg   <= scan_glyph;
      scan_an    <= an_next;
    end
  end

endmodule

// File: tb/tb_display_controller.sv
// Bench for display_controller: directed scenarios plus random traffic, all
// outputs compared every cycle against a count-based behavioural model.
module tb_display_controller;

  localparam int N  = 8;
  localparam int SD = 4;
  localparam int BD = 8;

  logic          clk;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [31:0]   load_data;
  logic [7:0]    blank_mask;
  logic [7:0]    blink_mask;
  logic          lz_en;
  logic          scan_mode;
  logic [55:0]   seg_static;
  logic [6:0]    scan_seg;
  logic [7:0]    scan_an;
  logic [1:0]    dbg_state;

  display_controller #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .lz_en(lz_en), .scan_mode(scan_mode), .seg_static(seg_static),
    .scan_seg(scan_seg), .scan_an(scan_an), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [6:0] ref_glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] m_shadow, m_disp;
  bit          m_pending, m_ready, prev_mode;
  int          s_cnt, b_cnt;
  logic [55:0] e_seg;
  logic [6:0]  e_scan_seg;
  logic [7:0]  e_an;

  task automatic model_reset();
    m_shadow = '0; m_disp = '0; m_pending = 0; m_ready = 0; prev_mode = 0;
    s_cnt = 0; b_cnt = 0;
    e_seg = {8{7'h40}}; e_scan_seg = 7'h7F; e_an = 8'hFF;
  endtask

  task automatic model_step();
    int   idx;
    bit   phase, wrap, blank;
    logic [6:0]  g;
    logic [55:0] segv;
    idx   = (s_cnt / SD) % N;
    phase = ((b_cnt / BD) % 2) == 1;
    segv  = '0;
    e_scan_seg = 7'h7F;
    for (int i = 0; i < N; i++) begin
      blank = blank_mask[i] || (blink_mask[i] && phase) ||
              (lz_en && i != 0 && (m_disp >> (4 * i)) == 0);
      g = blank ? 7'h7F : ref_glyph[4'(m_disp >> (4 * i))];
      segv[7*i +: 7] = g;
      if (scan_mode && i == idx) e_scan_seg = g;
    end
    e_seg = segv;
    e_an  = scan_mode ? ~(8'd1 << idx) : 8'hFF;
    wrap  = (scan_mode == prev_mode) && ((s_cnt % (SD * N)) == SD * N - 1);
    if (m_pending && (!scan_mode || wrap)) begin
      m_disp = m_shadow; m_pending = 0; m_ready = 1;
    end else if (m_ready && load_valid) begin
      m_shadow = load_data; m_pending = 1; m_ready = 0;
    end else if (!m_pending) begin
      m_ready = 1;
    end
    s_cnt = (scan_mode != prev_mode) ? 0 : s_cnt + 1;
    b_cnt = b_cnt + 1;
    prev_mode = scan_mode;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("load_ready", 64'(load_ready), 64'(m_ready));
    check("seg_static", 64'(seg_static), 64'(e_seg));
    check("scan_seg",   64'(scan_seg),   64'(e_scan_seg));
    check("scan_an",    64'(scan_an),    64'(e_an));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_load(input logic [31:0] d);
    load_data  = d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!load_ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_timeout", 64'(load_ready), 64'd1);
  endtask

  task automatic wait_an(input logic [7:0] v);
    int n = 0;
    while (scan_an !== v && n < 100) begin
      tick();
      n++;
    end
    check("an_timeout", 64'(scan_an), 64'(v));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(load_ready), 64'd0);
    check({tag, "_seg"},   64'(seg_static), 64'({8{7'h40}}));
    check({tag, "_sseg"},  64'(scan_seg),   64'h7F);
    check({tag, "_an"},    64'(scan_an),    64'hFF);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] d0_prev;
  logic [7:0] an_exp;

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; blank_mask = '0;
    blink_mask = '0; lz_en = 1'b0; scan_mode = 1'b0;
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 64'(load_ready), 64'd1);

    // Static mode load.
    do_load(32'h1234ABCD);
    check("034_ready_low", 64'(load_ready), 64'd0);
    tick();
    check("034_ready_back", 64'(load_ready), 64'd1);
    tick();
    check("034_d0", 64'(seg_static[6:0]), 64'h21);
    check("034_d7", 64'(seg_static[55:49]), 64'h79);

    // Leading-zero suppression.
    lz_en = 1'b1;
    do_load(32'h00000050);
    tick(); tick();
    check("035_hi", 64'(seg_static[55:14]), 64'({6{7'h7F}}));
    check("035_d1", 64'(seg_static[13:7]), 64'h12);
    check("035_d0", 64'(seg_static[6:0]), 64'h40);
    do_load(32'h0);
    tick(); tick();
    check("035_zero", 64'(seg_static), 64'({{7{7'h7F}}, 7'h40}));
    lz_en = 1'b0;

    // Blink on digit 0.
    do_load(32'h1234ABCD);
    blink_mask = 8'h01;
    repeat (20) tick();
    d0_prev = seg_static[6:0];
    repeat (BD) tick();
    check("037_toggle", 64'(seg_static[6:0]), 64'((d0_prev == 7'h7F) ? 7'h21 : 7'h7F));
    check("037_d7", 64'(seg_static[55:49]), 64'h79);
    blink_mask = 8'h00;

    // Scan mode: anode sequence, then a mid-frame load.
    scan_mode = 1'b1;
    tick();
    wait_an(8'h7F);
    wait_an(8'hFE);
    for (int k = 0; k < N; k++) begin
      an_exp = ~(8'd1 << k);
      check("036_an_seq", 64'(scan_an), 64'(an_exp));
      repeat (SD) tick();
    end
    repeat (8) tick();
    do_load(32'h89ABCDEF);
    check("036_ready_low", 64'(load_ready), 64'd0);
    repeat (4) tick();
    check("036_hold", 64'(seg_static[6:0]), 64'h21);
    wait_ready();
    tick();
    check("036_commit", 64'(seg_static[6:0]), 64'h0E);

    // Second load during a pending commit is ignored.
    do_load(32'h11111111);
    load_data  = 32'h22222222;
    load_valid = 1'b1;
    repeat (5) tick();
    load_valid = 1'b0;
    wait_ready();
    tick();
    check("038_first_kept", 64'(seg_static), 64'({8{7'h79}}));

    // Asynchronous reset while a commit is pending.
    do_load(32'h33333333);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("038_async");
    compare_all();
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("038_discard", 64'(seg_static), 64'({8{7'h40}}));

    // Random traffic.
    for (int r = 0; r < 400; r++) begin
      load_valid = ($urandom_range(0, 2) == 0);
      load_data  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0F0F) : $urandom;
      blank_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      blink_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 40) == 0) scan_mode = ~scan_mode;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
